// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - pixel-clock sync/DE timing generator with one-cycle-early pixel requests
//
// Ports:
//   pixel_clk, sys_rst_n       clock, asynchronous active-low reset
//   pixel_data[23:0]           RGB888 from renderer, returned one cycle after data_req
//   test_mode                  selects colour bars (COLOR_BAR_EN builds only)
//   pixel_xpos, pixel_ypos     requested coordinate, zero outside the request window
//   data_req                   coordinate request strobe, one cycle ahead of video_de
//   video_hs, video_vs         sync outputs, polarity set by HS_POL / VS_POL
//   video_de, video_rgb        data enable and aligned RGB888 to encoder
//   frame_start                high while h_cnt = 0 and v_cnt = 0
//
// Optional build macro: COLOR_BAR_EN adds an eight-bar test pattern selected by test_mode.
module video_timing_gen #(
    parameter logic [10:0] H_SYNC  = 11'd40,
    parameter logic [10:0] H_BACK  = 11'd220,
    parameter logic [10:0] H_DISP  = 11'd1280,
    parameter logic [10:0] H_FRONT = 11'd110,
    parameter logic [10:0] V_SYNC  = 11'd5,
    parameter logic [10:0] V_BACK  = 11'd20,
    parameter logic [10:0] V_DISP  = 11'd720,
    parameter logic [10:0] V_FRONT = 11'd5,
    parameter logic        HS_POL  = 1'b1,
    parameter logic        VS_POL  = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] pixel_data,
    input  logic        test_mode,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        data_req,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start
);

    localparam logic [10:0] H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] H_ACT     = H_SYNC + H_BACK;
    localparam logic [10:0] H_END     = H_ACT + H_DISP;
    localparam logic [10:0] H_REQ     = H_ACT - 11'd1;
    localparam logic [10:0] H_REQ_END = H_END - 11'd1;
    localparam logic [10:0] V_ACT     = V_SYNC + V_BACK;
    localparam logic [10:0] V_END     = V_ACT + V_DISP;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        v_win;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else if (h_cnt == H_TOTAL - 11'd1) begin
            h_cnt <= 11'd0;
            v_cnt <= (v_cnt == V_TOTAL - 11'd1) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign v_win       = (v_cnt >= V_ACT) && (v_cnt < V_END);
    assign video_hs    = (h_cnt < H_SYNC) ? HS_POL : ~HS_POL;
    assign video_vs    = (v_cnt < V_SYNC) ? VS_POL : ~VS_POL;
    assign video_de    = v_win && (h_cnt >= H_ACT) && (h_cnt < H_END);
    // Request leads DE by one pixel so the renderer's registered data lands on DE.
    assign data_req    = v_win && (h_cnt >= H_REQ) && (h_cnt < H_REQ_END);
    assign pixel_xpos  = data_req ? (h_cnt - H_REQ) : 11'd0;
    assign pixel_ypos  = data_req ? (v_cnt - V_ACT) : 11'd0;
    assign frame_start = (h_cnt == 11'd0) && (v_cnt == 11'd0);

`ifdef COLOR_BAR_EN
    localparam logic [10:0] BAR_W = H_DISP / 11'd8;

    logic [23:0] bar_rgb;
    logic [23:0] bar_next;

    // Comparator chain on the requested x; bar order is white, yellow, cyan,
    // green, magenta, red, blue, black.
    always_comb begin
        bar_next = 24'h000000;
        if      (pixel_xpos < BAR_W)          bar_next = 24'hFFFFFF;
        else if (pixel_xpos < BAR_W * 11'd2)  bar_next = 24'hFFFF00;
        else if (pixel_xpos < BAR_W * 11'd3)  bar_next = 24'h00FFFF;
        else if (pixel_xpos < BAR_W * 11'd4)  bar_next = 24'h00FF00;
        else if (pixel_xpos < BAR_W * 11'd5)  bar_next = 24'hFF00FF;
        else if (pixel_xpos < BAR_W * 11'd6)  bar_next = 24'hFF0000;
        else if (pixel_xpos < BAR_W * 11'd7)  bar_next = 24'h0000FF;
        else                                  bar_next = 24'h000000;
    end

    // Registered on the request cycle, so it lines up with DE like pixel_data.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bar_rgb <= 24'h000000;
        end else if (data_req) begin
            bar_rgb <= bar_next;
        end
    end

    assign video_rgb = !video_de ? 24'h000000 : (test_mode ? bar_rgb : pixel_data);
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign video_rgb = video_de ? pixel_data : 24'h000000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen (two parameter sets)
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test_mode = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;
    int n = 0;

    // Set A: small frame 29 x 15; set B: inverted sync, 640 wide, 653 x 11.
    logic [10:0] a_x, a_y, b_x, b_y;
    logic a_req, a_hs, a_vs, a_de, a_fs, b_req, b_hs, b_vs, b_de, b_fs;
    logic [23:0] a_rgb, b_rgb, a_pd, b_pd;

    video_timing_gen #(
        .H_SYNC(11'd4), .H_BACK(11'd6), .H_DISP(11'd16), .H_FRONT(11'd3),
        .V_SYNC(11'd2), .V_BACK(11'd3), .V_DISP(11'd8), .V_FRONT(11'd2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_a (
        .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(a_pd), .test_mode(test_mode),
        .pixel_xpos(a_x), .pixel_ypos(a_y), .data_req(a_req), .video_hs(a_hs),
        .video_vs(a_vs), .video_de(a_de), .video_rgb(a_rgb), .frame_start(a_fs)
    );

    video_timing_gen #(
        .H_SYNC(11'd4), .H_BACK(11'd6), .H_DISP(11'd640), .H_FRONT(11'd3),
        .V_SYNC(11'd2), .V_BACK(11'd3), .V_DISP(11'd4), .V_FRONT(11'd2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(b_pd), .test_mode(test_mode),
        .pixel_xpos(b_x), .pixel_ypos(b_y), .data_req(b_req), .video_hs(b_hs),
        .video_vs(b_vs), .video_de(b_de), .video_rgb(b_rgb), .frame_start(b_fs)
    );

    // Renderer: returns {x, y, A5} one cycle after the request.
    always @(posedge clk) begin
        a_pd <= {a_x[7:0], a_y[7:0], 8'hA5};
        b_pd <= {b_x[7:0], b_y[7:0], 8'hA5};
    end

    // Cycles elapsed since reset release; position follows by division.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    typedef struct {
        logic        hs, vs, de, req, fs;
        logic [10:0] x, y;
        logic [23:0] rgb;
    } exp_t;

    function automatic logic [23:0] bar_colour(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic exp_t model(input int cyc, input int hs_w, input int hb, input int hd,
                                   input int hf, input int vs_w, input int vb, input int vd,
                                   input int vf, input logic hp, input logic vp, input logic tm);
        exp_t e;
        int ht, vt, h, v, ha, va;
        logic vin;
        logic [31:0] px, py;
        ht = hs_w + hb + hd + hf;
        vt = vs_w + vb + vd + vf;
        h = cyc % ht;
        v = (cyc / ht) % vt;
        ha = hs_w + hb;
        va = vs_w + vb;
        vin = (v >= va) && (v < va + vd);
        e.hs = (h < hs_w) ? hp : ~hp;
        e.vs = (v < vs_w) ? vp : ~vp;
        e.fs = (h == 0) && (v == 0);
        e.req = vin && (h >= ha - 1) && (h < ha + hd - 1);
        e.de = vin && (h >= ha) && (h < ha + hd);
        e.x = e.req ? 11'(h - ha + 1) : 11'd0;
        e.y = e.req ? 11'(v - va) : 11'd0;
        e.rgb = 24'h000000;
        if (e.de) begin
            px = 32'(h - ha);
            py = 32'(v - va);
            e.rgb = {px[7:0], py[7:0], 8'hA5};
`ifdef COLOR_BAR_EN
            if (tm) e.rgb = bar_colour(int'(px) / (hd / 8));
`endif
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            exp_t ea, eb;
            ea = model(n, 4, 6, 16, 3, 2, 3, 8, 2, 1'b1, 1'b1, test_mode);
            eb = model(n, 4, 6, 640, 3, 2, 3, 4, 2, 1'b0, 1'b0, test_mode);
            check("a_hs", 24'(a_hs), 24'(ea.hs));
            check("a_vs", 24'(a_vs), 24'(ea.vs));
            check("a_de", 24'(a_de), 24'(ea.de));
            check("a_req", 24'(a_req), 24'(ea.req));
            check("a_fs", 24'(a_fs), 24'(ea.fs));
            check("a_xpos", 24'(a_x), 24'(ea.x));
            check("a_ypos", 24'(a_y), 24'(ea.y));
            check("a_rgb", a_rgb, ea.rgb);
            check("b_hs", 24'(b_hs), 24'(eb.hs));
            check("b_vs", 24'(b_vs), 24'(eb.vs));
            check("b_de", 24'(b_de), 24'(eb.de));
            check("b_req", 24'(b_req), 24'(eb.req));
            check("b_fs", 24'(b_fs), 24'(eb.fs));
            check("b_xpos", 24'(b_x), 24'(eb.x));
            check("b_ypos", 24'(b_y), 24'(eb.y));
            check("b_rgb", b_rgb, eb.rgb);
        end
    end

    initial begin
        int fs_cnt, fs_pos0, fs_pos1, de_cnt, hs_hi, vs_hi, de_line_a, first_de_c;
        int de_line_b, hs_lo_b, max_x_b, waited;
        logic seen_first;
        logic [23:0] first_rgb, last_rgb_a, last_rgb_b;
        fs_cnt = 0; fs_pos0 = 0; fs_pos1 = 0; de_cnt = 0; hs_hi = 0; vs_hi = 0;
        de_line_a = 0; first_de_c = -1; de_line_b = 0; hs_lo_b = 0; max_x_b = 0;
        seen_first = 1'b0; first_rgb = '0; last_rgb_a = '0; last_rgb_b = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_fs", 24'(a_fs), 24'd1);
        check("rst_a_hs", 24'(a_hs), 24'd1);
        check("rst_a_vs", 24'(a_vs), 24'd1);
        check("rst_a_de", 24'(a_de), 24'd0);
        check("rst_a_rgb", a_rgb, 24'h000000);
        check("rst_b_hs", 24'(b_hs), 24'd0);
        check("rst_b_vs", 24'(b_vs), 24'd0);
        chk_en = 1'b1;

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 7200; c++) begin
            if (c < 870) begin
                if (a_fs) begin
                    if (fs_cnt == 0) fs_pos0 = c;
                    else if (fs_cnt == 1) fs_pos1 = c;
                    fs_cnt++;
                end
                if (a_de) de_cnt++;
                if (c < 29 && a_hs) hs_hi++;
                if (c < 435 && a_vs) vs_hi++;
                if (a_de && !seen_first) begin
                    seen_first = 1'b1;
                    first_rgb = a_rgb;
                    first_de_c = c;
                end
                if (a_de && (c / 29) == 5) begin
                    de_line_a++;
                    last_rgb_a = a_rgb;
                end
            end
            if (b_req && int'(b_x) > max_x_b) max_x_b = int'(b_x);
            if (b_de && (c / 653) == 5) begin
                de_line_b++;
                last_rgb_b = b_rgb;
            end
            if (c < 653 && !b_hs) hs_lo_b++;
            @(negedge clk);
            #1;
        end
        check("a_fs_count", 24'(fs_cnt), 24'd2);
        check("a_fs_period", 24'(fs_pos1 - fs_pos0), 24'd435);
        check("a_de_per_frame", 24'(de_cnt / 2), 24'd128);
        check("a_hs_width", 24'(hs_hi), 24'd4);
        check("a_vs_width", 24'(vs_hi), 24'd58);
        check("a_first_de_cycle", 24'(first_de_c), 24'd155);
        check("a_first_rgb", first_rgb, 24'h0000A5);
        check("a_de_per_line", 24'(de_line_a), 24'd16);
        check("a_last_rgb", last_rgb_a, 24'h0F00A5);
        check("b_xpos_max", 24'(max_x_b), 24'd639);
        check("b_de_per_line", 24'(de_line_b), 24'd640);
        check("b_last_rgb", last_rgb_b, 24'h7F00A5);
        check("b_hs_low_width", 24'(hs_lo_b), 24'd4);

        // Asynchronous reset in the middle of an active line of set A
        waited = 0;
        while (!((n % 29) == 15 && ((n / 29) % 15) == 7) && waited < 500) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("rst_wait_timeout", 24'(waited >= 500), 24'd0);
        check("pre_rst_a_de", 24'(a_de), 24'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_a_fs", 24'(a_fs), 24'd1);
        check("async_a_hs", 24'(a_hs), 24'd1);
        check("async_a_vs", 24'(a_vs), 24'd1);
        check("async_a_de", 24'(a_de), 24'd0);
        check("async_a_req", 24'(a_req), 24'd0);
        check("async_a_xpos", 24'(a_x), 24'd0);
        check("async_a_rgb", a_rgb, 24'h000000);
        check("async_b_hs", 24'(b_hs), 24'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_a_fs", 24'(a_fs), 24'd1);
        check("release_b_fs", 24'(b_fs), 24'd1);

        // Test mode on: bars when built with COLOR_BAR_EN, else ignored
        test_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
`ifdef COLOR_BAR_EN
            if (c == 155)  check("bar_a_x0", a_rgb, 24'hFFFFFF);
            if (c == 157)  check("bar_a_x2", a_rgb, 24'hFFFF00);
            if (c == 170)  check("bar_a_x15", a_rgb, 24'h000000);
            if (c == 3275) check("bar_b_x0", b_rgb, 24'hFFFFFF);
            if (c == 3355) check("bar_b_x80", b_rgb, 24'hFFFF00);
            if (c == 3914) check("bar_b_x639", b_rgb, 24'h000000);
`else
            if (c == 155)  check("tm_a_x0", a_rgb, 24'h0000A5);
            if (c == 157)  check("tm_a_x2", a_rgb, 24'h0200A5);
            if (c == 170)  check("tm_a_x15", a_rgb, 24'h0F00A5);
            if (c == 3275) check("tm_b_x0", b_rgb, 24'h0000A5);
            if (c == 3355) check("tm_b_x80", b_rgb, 24'h5000A5);
            if (c == 3914) check("tm_b_x639", b_rgb, 24'h7F00A5);
`endif
            @(negedge clk);
            #1;
        end
        test_mode = 1'b0;
        repeat (450) @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
